nibble_packer: RTL and testbench
================================

# nibble_packer

Assembles a stream of 4-bit nibbles into 8-bit bytes, most-significant nibble first, and buffers the completed bytes in a small FIFO. The output side uses a valid/ready handshake. This is the reassembly counterpart to the byte-to-nibble and bit-slicing manipulation used in the signal-manipulation tasks. It sits between any nibble-wide producer and a byte-wide consumer.

## Interface
- DEPTH, 4, number of byte entries in the output FIFO. Must be a power of 2 and ≥ 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- nib_in  in  4  nibble data.
- nib_valid  in  1  producer has a nibble on nib_in.
- nib_ready  out  1  packer can accept a nibble this cycle.
- flush  in  1  emit a pending half-byte, zero-padded.
- byte_out  out  8  FIFO head byte.
- byte_valid  out  1  FIFO is non-empty.
- byte_ready  in  1  consumer takes byte_out this cycle.
- fill  out  $clog2(DEPTH)+1  number of bytes held in the FIFO.
- pending  out  1  an upper nibble is held and waiting for its lower nibble.

## Operation
- Nibble accept: nib_valid && nib_ready at a rising edge.
- Packer states:
  - IDLE (pending=0):
    - Accepted nibble is stored in hi_reg; next state is HALF.
  - HALF (pending=1):
    - Accepted nibble completes the byte {hi_reg, nib_in}, which is pushed into the FIFO.
    - Next state is IDLE.
- nib_ready = !pending || (fill != DEPTH). It depends on registers only and never combinationally on byte_ready.
- Flush, evaluated on the state before the edge:
  - HALF, no nibble accepted, FIFO not full: push {hi_reg, 4'b0000} and go to IDLE.
  - HALF with a nibble accepted the same cycle: normal completion; flush adds nothing.
  - IDLE: no-op.
  - HALF with FIFO full: ignored; the caller holds flush until it takes effect.
- FIFO:
  - Unpacked array mem[DEPTH] of 8-bit entries.
  - Read and write pointers wrap modulo DEPTH.
  - byte_out = mem[rd_ptr].
  - byte_valid = (fill != 0).
- Pop: byte_valid && byte_ready.
- Push and pop in the same cycle: both happen and fill is unchanged. This is legal at any fill level where the push is permitted.
- byte_ready while byte_valid=0 has no effect.
- Reset values:
  - pending=0, fill=0, byte_valid=0, nib_ready=1, byte_out=8'h00.
  - All mem entries and hi_reg are cleared.
  - Pointers are 0.
- Reset asserted mid-byte discards hi_reg and all buffered bytes immediately (asynchronous).

## Timing
- Latency from the second nibble's accept edge to byte_valid=1 is one edge; the byte is visible in the cycle after the edge when the FIFO was empty.
- Flush-to-byte latency is one edge.
- Sustained throughput is one nibble per cycle, so one byte per two cycles, when byte_ready is held at 1.
- fill, pending and nib_ready update only on the clock edge or asynchronously on reset.
- byte_out is stable while byte_valid=1 and byte_ready=0. The consumer may rely on this.

## Configuration
- NIBBLE_PACKER_PARITY_EN defined:
  - Adds output byte_par (out, 1) = ^byte_out, the even-parity bit of the FIFO head.
  - byte_par is 0 in reset.
- Macro undefined: the byte_par port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then nibbles 4'hA then 4'hF with byte_ready=1:
  - pending=1 after the first edge.
  - byte_out=8'hAF and byte_valid=1 after the second edge.
  - fill returns to 0 after the pop.
- Nibble 4'hE, then flush=1 for one cycle:
  - byte_out=8'hE0.
  - pending=0.
  - With the parity macro, byte_par=1.
- byte_ready=0, stream 2·DEPTH nibbles 1,2,3…:
  - fill reaches DEPTH.
  - The next upper nibble is accepted (pending=1), then nib_ready=0.
  - Draining yields 8'h12, 8'h34, 8'h56, 8'h78 in order, proving pointer wrap on refill.
- Full FIFO, pending=1, flush held:
  - No push while full.
  - One pop lets the flush push {hi,0}.
- Simultaneous push and pop at fill=2: fill stays 2 and output order is preserved.
- Assert rst_n=0 while pending=1 and fill=3:
  - All outputs take their reset values without waiting for a clock edge.
  - The first byte after release is built from fresh nibbles only.

Source files
------------

// File: rtl/nibble_packer.sv
// Packs 4-bit nibbles (upper nibble first) into bytes and queues them in a DEPTH-entry FIFO.
// Define NIBBLE_PACKER_PARITY_EN to add the byte_par output (even parity of the FIFO head).
module nibble_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               nib_in,
  input  logic                     nib_valid,
  output logic                     nib_ready,
  input  logic                     flush,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     pending
`ifdef NIBBLE_PACKER_PARITY_EN
  ,
  output logic                     byte_par
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, HALF = 1'b1} state_t;

  state_t        state_q;
  logic [3:0]    hi_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   fill_q;

  logic          full;
  logic          accept;
  logic          pop;
  logic          push;
  logic [7:0]    push_data;
  state_t        state_d;
  logic [AW:0]   fill_d;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends combinationally on the same interface's valid or on byte_ready.
  assign full       = (fill_q == FULL_LVL);
  assign pending    = (state_q == HALF);
  assign nib_ready  = !pending || !full;
  assign accept     = nib_valid && nib_ready;
  assign byte_valid = (fill_q != '0);
  assign pop        = byte_valid && byte_ready;
  assign byte_out   = mem_q[rd_ptr_q];
  assign fill       = fill_q;

`ifdef NIBBLE_PACKER_PARITY_EN
  assign byte_par = ^byte_out;
`endif

  always_comb begin
    push      = 1'b0;
    push_data = {hi_q, nib_in};
    state_d   = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = HALF;
      end
      HALF: begin
        if (accept) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (flush && !full) begin
          // Flush pads the held upper nibble; a same-cycle nibble takes priority.
          push      = 1'b1;
          push_data = {hi_q, 4'b0000};
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      if (state_q == IDLE && accept) hi_q <= nib_in;
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (DEPTH=4), covering the
// NIBBLE_PACKER_PARITY_EN build when that macro is defined.
module tb_nibble_packer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       nib_ready;
  logic       flush;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic [2:0] fill;
  logic       pending;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic       byte_par;
`endif

  int checks = 0;
  int errors = 0;

  nibble_packer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nib_in     (nib_in),
    .nib_valid  (nib_valid),
    .nib_ready  (nib_ready),
    .flush      (flush),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .fill       (fill),
    .pending    (pending)
`ifdef NIBBLE_PACKER_PARITY_EN
    ,
    .byte_par   (byte_par)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one cycle: inputs set after this return are sampled at the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    nib_in    = n;
    nib_valid = 1'b1;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pending"}, 32'(pending), 32'h0);
    chk({tag, "_fill"}, 32'(fill), 32'h0);
    chk({tag, "_bvalid"}, 32'(byte_valid), 32'h0);
    chk({tag, "_nready"}, 32'(nib_ready), 32'h1);
    chk({tag, "_bout"}, 32'(byte_out), 32'h00);
`ifdef NIBBLE_PACKER_PARITY_EN
    chk({tag, "_bpar"}, 32'(byte_par), 32'h0);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    nib_in     = 4'h0;
    nib_valid  = 1'b0;
    flush      = 1'b0;
    byte_ready = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // A then F with byte_ready=1
    byte_ready = 1'b1;
    send_nib(4'hA);
    chk("af_pending1", 32'(pending), 32'h1);
    chk("af_bvalid0", 32'(byte_valid), 32'h0);
    send_nib(4'hF);
    chk("af_bout", 32'(byte_out), 32'hAF);
    chk("af_bvalid", 32'(byte_valid), 32'h1);
    chk("af_fill1", 32'(fill), 32'h1);
    chk("af_pending0", 32'(pending), 32'h0);
    nib_valid = 1'b0;
    step();
    chk("af_fill_popped", 32'(fill), 32'h0);
    chk("af_bvalid_popped", 32'(byte_valid), 32'h0);

    // E then flush
    send_nib(4'hE);
    chk("fl_pending1", 32'(pending), 32'h1);
    nib_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_bout", 32'(byte_out), 32'hE0);
    chk("fl_bvalid", 32'(byte_valid), 32'h1);
    chk("fl_pending0", 32'(pending), 32'h0);
`ifdef NIBBLE_PACKER_PARITY_EN
    chk("fl_bpar", 32'(byte_par), 32'h1);
`endif
    step();
    chk("fl_fill_popped", 32'(fill), 32'h0);

    // fill the FIFO with 12,34,56,78 while the consumer stalls
    byte_ready = 1'b0;
    for (int i = 1; i <= 2 * DEPTH; i++) send_nib(4'(i));
    chk("full_fill", 32'(fill), 32'h4);
    chk("full_pending0", 32'(pending), 32'h0);
    chk("full_nready_idle", 32'(nib_ready), 32'h1);
    chk("full_head", 32'(byte_out), 32'h12);
    send_nib(4'h9);
    chk("full_pending1", 32'(pending), 32'h1);
    chk("full_nready0", 32'(nib_ready), 32'h0);

    // flush held while full: nothing pushed
    nib_valid = 1'b0;
    flush     = 1'b1;
    step();
    chk("flfull_fill", 32'(fill), 32'h4);
    chk("flfull_pending", 32'(pending), 32'h1);
    chk("flfull_head", 32'(byte_out), 32'h12);

    // drain; the flush lands one edge after the first pop frees a slot
    byte_ready = 1'b1;
    step();
    chk("dr_head34", 32'(byte_out), 32'h34);
    chk("dr_fill3", 32'(fill), 32'h3);
    chk("dr_pending_still", 32'(pending), 32'h1);
    step();
    flush = 1'b0;
    chk("dr_head56", 32'(byte_out), 32'h56);
    chk("dr_fill3_pushpop", 32'(fill), 32'h3);
    chk("dr_pending0", 32'(pending), 32'h0);
    step();
    chk("dr_head78", 32'(byte_out), 32'h78);
    chk("dr_fill2", 32'(fill), 32'h2);
    step();
    chk("dr_head90", 32'(byte_out), 32'h90);
    chk("dr_fill1", 32'(fill), 32'h1);
    step();
    chk("dr_empty", 32'(byte_valid), 32'h0);
    chk("dr_fill0", 32'(fill), 32'h0);

    // simultaneous push and pop at fill=2
    byte_ready = 1'b0;
    send_nib(4'hA);
    send_nib(4'hB);
    send_nib(4'hC);
    send_nib(4'hD);
    chk("pp_fill2", 32'(fill), 32'h2);
    chk("pp_headAB", 32'(byte_out), 32'hAB);
    send_nib(4'h5);
    byte_ready = 1'b1;
    send_nib(4'h6);
    nib_valid = 1'b0;
    chk("pp_fill_same", 32'(fill), 32'h2);
    chk("pp_headCD", 32'(byte_out), 32'hCD);
    step();
    chk("pp_head56", 32'(byte_out), 32'h56);
    chk("pp_fill1", 32'(fill), 32'h1);
    step();
    chk("pp_fill0", 32'(fill), 32'h0);

    // asynchronous reset with pending=1 and fill=3
    byte_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send_nib(4'(i));
    nib_valid = 1'b0;
    chk("ar_pre_fill", 32'(fill), 32'h3);
    chk("ar_pre_pending", 32'(pending), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("ar");
    step();
    rst_n = 1'b1;
    step();
    send_nib(4'hC);
    send_nib(4'hD);
    nib_valid = 1'b0;
    chk("ar_fresh_bout", 32'(byte_out), 32'hCD);
    chk("ar_fresh_fill", 32'(fill), 32'h1);
    chk("ar_fresh_pending", 32'(pending), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
